// File: rtl/motor_dac_spi_tx.sv
// Serialises motor ramp samples to an SPI DAC as {DAC_CMD, sample} frames.
// One sample can wait in a pending register while a frame is in flight;
// newer strobes replace it and are counted as overwrites.
module motor_dac_spi_tx #(
  parameter real        TCQ        = 0.1,
  parameter int         MOTOR_VOL  = 16,
  parameter logic [7:0] DAC_CMD    = 8'h00,
  parameter int         GAP_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           sclk_div_i,
  input  logic                 motor_data_en_i,
  input  logic [MOTOR_VOL-1:0] motor_data_i,
  output logic                 dac_sclk_o,
  output logic                 dac_sync_n_o,
  output logic                 dac_sdo_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [15:0]          overwrite_cnt_o
);

  localparam int         FRAME_W  = 8 + MOTOR_VOL;
  localparam int         BIT_W    = $clog2(FRAME_W + 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  // Registers carry no modelled delay; TCQ only documents the intended
  // clock-to-Q for downstream timing models. Out-of-range settings land here.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255 || TCQ < 0.0) begin : g_bad_params
  end

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state, state_nxt;
  logic [7:0]           half, half_nxt;
  logic [7:0]           cnt, cnt_nxt;
  logic [BIT_W-1:0]     bits_left, bits_nxt;
  logic [FRAME_W-1:0]   shreg, shreg_nxt;
  logic                 sclk, sclk_nxt;
  logic                 sync_n, sync_n_nxt;
  logic                 done, done_nxt;
  logic                 pend_vld, pend_vld_nxt;
  logic [MOTOR_VOL-1:0] pend_data, pend_data_nxt;
  logic [15:0]          ovw_cnt, ovw_nxt;
  logic                 phase_end;
  logic                 start;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] clamp_div(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  // A half-period of H cycles ends when the phase counter reaches H-1.
  assign phase_end = (cnt == half - 8'd1);

  // A frame may begin from IDLE or from the final GAP cycle.
  assign start = ((state == IDLE) || ((state == GAP) && (cnt == GAP_LAST))) &&
                 (motor_data_en_i || pend_vld);

  // Next-state, serial timing and pending-sample bookkeeping.
  always_comb begin
    state_nxt     = state;
    half_nxt      = half;
    cnt_nxt       = cnt;
    bits_nxt      = bits_left;
    shreg_nxt     = shreg;
    sclk_nxt      = sclk;
    sync_n_nxt    = sync_n;
    done_nxt      = 1'b0;
    pend_vld_nxt  = pend_vld;
    pend_data_nxt = pend_data;
    ovw_nxt       = ovw_cnt;

    // At a frame start the pending sample (if any) is consumed, so a strobe
    // in the same cycle simply becomes the new pending sample.
    if (start) begin
      pend_vld_nxt = pend_vld & motor_data_en_i;
      if (motor_data_en_i) begin
        pend_data_nxt = motor_data_i;
      end
    end else if (motor_data_en_i) begin
      if (pend_vld) begin
        ovw_nxt = sat_inc(ovw_cnt);
      end
      pend_vld_nxt  = 1'b1;
      pend_data_nxt = motor_data_i;
    end

    case (state)
      IDLE: begin
        cnt_nxt = 8'd0;
      end
      SETUP: begin
        if (phase_end) begin
          state_nxt = SHIFT;
          sclk_nxt  = 1'b0;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (!phase_end) begin
          cnt_nxt = cnt + 8'd1;
        end else begin
          cnt_nxt = 8'd0;
          if (!sclk) begin
            // Rising sclk: present the next bit for the following low phase.
            sclk_nxt  = 1'b1;
            shreg_nxt = shreg << 1;
          end else if (bits_left == BIT_W'(1)) begin
            state_nxt = HOLD;
          end else begin
            sclk_nxt = 1'b0;
            bits_nxt = bits_left - 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_nxt  = GAP;
          sync_n_nxt = 1'b1;
          done_nxt   = 1'b1;
          cnt_nxt    = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (start) begin
      state_nxt  = SETUP;
      half_nxt   = clamp_div(sclk_div_i);
      cnt_nxt    = 8'd0;
      bits_nxt   = BIT_W'(FRAME_W);
      shreg_nxt  = {DAC_CMD, (pend_vld ? pend_data : motor_data_i)};
      sync_n_nxt = 1'b0;
      sclk_nxt   = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      half      <= 8'd1;
      cnt       <= 8'd0;
      bits_left <= '0;
      shreg     <= '0;
      sclk      <= 1'b1;
      sync_n    <= 1'b1;
      done      <= 1'b0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      ovw_cnt   <= 16'd0;
    end else begin
      state     <= state_nxt;
      half      <= half_nxt;
      cnt       <= cnt_nxt;
      bits_left <= bits_nxt;
      shreg     <= shreg_nxt;
      sclk      <= sclk_nxt;
      sync_n    <= sync_n_nxt;
      done      <= done_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_data <= pend_data_nxt;
      ovw_cnt   <= ovw_nxt;
    end
  end

  assign dac_sclk_o      = sclk;
  assign dac_sync_n_o    = sync_n;
  assign dac_sdo_o       = shreg[FRAME_W-1];
  assign busy_o          = (state != IDLE);
  assign frame_done_o    = done;
  assign overwrite_cnt_o = ovw_cnt;

endmodule

// File: tb/tb_motor_dac_spi_tx.sv
// Bench for motor_dac_spi_tx: table-driven frames, hand-written corner
// sequences, and a cycle-by-cycle reference model under random strobes.
module tb_motor_dac_spi_tx;

  localparam int FW  = 24;
  localparam int GAP = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  sclk_div_i = 8'd1;
  logic        motor_data_en_i = 1'b0;
  logic [15:0] motor_data_i = 16'h0;
  logic        dac_sclk_o, dac_sync_n_o, dac_sdo_o, busy_o, frame_done_o;
  logic [15:0] overwrite_cnt_o;

  motor_dac_spi_tx dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .sclk_div_i      (sclk_div_i),
    .motor_data_en_i (motor_data_en_i),
    .motor_data_i    (motor_data_i),
    .dac_sclk_o      (dac_sclk_o),
    .dac_sync_n_o    (dac_sync_n_o),
    .dac_sdo_o       (dac_sdo_o),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
    .overwrite_cnt_o (overwrite_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Frame timeline measured from the first sync-low cycle (k=0):
  // setup H, 24 bits of (low H, high H), hold H, then GAP idle cycles.
  int          m_t = 0, m_s = 0, m_h = 1;
  bit          m_active = 0, m_pv = 0;
  logic [15:0] m_pd = 0, m_ovw = 0;
  logic [23:0] m_frame = 0;

  task automatic model_step();
    int  len, kk;
    bit  last;
    if (rst_i) begin
      m_active = 0; m_pv = 0; m_ovw = 0;
    end else begin
      len  = 50 * m_h;
      kk   = m_t - m_s;
      last = m_active && (kk == len + GAP - 1);
      if ((!m_active || last) && (motor_data_en_i || m_pv)) begin
        m_frame  = {8'h00, (m_pv ? m_pd : motor_data_i)};
        m_pv     = m_pv && motor_data_en_i;
        m_pd     = motor_data_i;
        m_active = 1;
        m_s      = m_t + 1;
        m_h      = (sclk_div_i == 0) ? 1 : int'(sclk_div_i);
      end else begin
        if (last) m_active = 0;
        if (motor_data_en_i) begin
          if (m_pv && m_ovw != 16'hFFFF) m_ovw = m_ovw + 16'd1;
          m_pd = motor_data_i;
          m_pv = 1;
        end
      end
    end
    m_t++;
  endtask

  task automatic model_check();
    logic [4:0] exp_v, act_v;
    int k, len, j, b, idx;
    bit low;
    exp_v = 5'b11000; // sync_n, sclk, sdo, busy, done
    if (m_active) begin
      k = m_t - m_s;
      len = 50 * m_h;
      exp_v[1] = 1'b1;
      if (k < len) begin
        exp_v[4] = 1'b0;
        if (k < m_h) begin
          exp_v[2] = m_frame[FW-1];
        end else if (k < m_h + 48 * m_h) begin
          j   = k - m_h;
          b   = j / (2 * m_h);
          low = (j % (2 * m_h)) < m_h;
          exp_v[3] = !low;
          idx = low ? b : b + 1;
          exp_v[2] = (idx < FW) ? m_frame[FW-1-idx] : 1'b0;
        end
      end else begin
        exp_v[0] = (k == len);
      end
    end
    act_v = {dac_sync_n_o, dac_sclk_o, dac_sdo_o, busy_o, frame_done_o};
    check("cycle_outputs", 32'(act_v), 32'(exp_v));
    check("cycle_overwrite_cnt", 32'(overwrite_cnt_o), 32'(m_ovw));
  endtask

  always @(posedge clk_i) begin
    model_step();
    #1;
    model_check();
  end

  // ---------------- serial-line monitor ----------------
  typedef struct {
    logic [23:0] bits;
    int          low;
    int          pulses;
    int          gap;
  } frame_t;

  frame_t fq[$];
  int     done_cnt = 0;
  logic   prev_sync = 1'b1, prev_sclk = 1'b1;
  bit     in_frame = 0;
  frame_t cur;
  int     highrun = 1000;

  always @(negedge clk_i) begin
    if (frame_done_o === 1'b1) done_cnt++;
    if (dac_sync_n_o === 1'b0) begin
      if (prev_sync) begin
        in_frame   = 1;
        cur.bits   = '0;
        cur.low    = 0;
        cur.pulses = 0;
        cur.gap    = highrun;
      end
      cur.low++;
      if (prev_sclk && !dac_sclk_o) begin
        cur.bits = {cur.bits[22:0], dac_sdo_o};
        cur.pulses++;
      end
    end else begin
      if (!prev_sync && in_frame) fq.push_back(cur);
      in_frame = 0;
      highrun  = prev_sync ? highrun + 1 : 1;
    end
    prev_sync = dac_sync_n_o;
    prev_sclk = dac_sclk_o;
  end

  // ---------------- helpers ----------------
  task automatic wait_frame(output frame_t f);
    int n = 0;
    f = '{bits: '0, low: 0, pulses: 0, gap: 0};
    while (fq.size() == 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (fq.size() == 0) check("frame_timeout", 32'd0, 32'd1);
    else f = fq.pop_front();
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while (busy_o !== 1'b0 && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o !== 1'b0) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic strobe(input logic [15:0] d);
    @(negedge clk_i);
    motor_data_en_i = 1'b1;
    motor_data_i    = d;
    @(negedge clk_i);
    motor_data_en_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  div;
    logic [15:0] data;
    logic [23:0] exp_bits;
    int          exp_low;
  } vec_t;

  vec_t   vt[4];
  frame_t f;
  int     d0;

  initial begin
    vt[0] = '{div: 8'd1, data: 16'hA5C3, exp_bits: 24'h00A5C3, exp_low: 50};
    vt[1] = '{div: 8'd0, data: 16'h1234, exp_bits: 24'h001234, exp_low: 50};
    vt[2] = '{div: 8'd3, data: 16'hFFFF, exp_bits: 24'h00FFFF, exp_low: 150};
    vt[3] = '{div: 8'd2, data: 16'h8001, exp_bits: 24'h008001, exp_low: 100};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("reset_sync_n", 32'(dac_sync_n_o), 32'd1);
    check("reset_sclk", 32'(dac_sclk_o), 32'd1);
    check("reset_sdo", 32'(dac_sdo_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(frame_done_o), 32'd0);
    check("reset_ovw", 32'(overwrite_cnt_o), 32'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    fq.delete();

    // Single frames from IDLE at several divider settings
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      sclk_div_i      = vt[i].div;
      motor_data_en_i = 1'b1;
      motor_data_i    = vt[i].data;
      d0 = done_cnt;
      @(posedge clk_i);
      #1 check("start_latency", 32'(dac_sync_n_o), 32'd0);
      @(negedge clk_i);
      motor_data_en_i = 1'b0;
      wait_frame(f);
      check("vec_bits", 32'(f.bits), 32'(vt[i].exp_bits));
      check("vec_sync_low", 32'(f.low), 32'(vt[i].exp_low));
      check("vec_sclk_pulses", 32'(f.pulses), 32'd24);
      wait_idle();
      check("vec_done_pulses", 32'(done_cnt - d0), 32'd1);
    end

    // Overwrite: first strobe starts a frame, the next two fight for pending
    sclk_div_i = 8'd1;
    strobe(16'h0001);
    strobe(16'h0002);
    strobe(16'h0003);
    wait_frame(f);
    check("ovw_first_bits", 32'(f.bits), 32'h000001);
    wait_frame(f);
    check("ovw_second_bits", 32'(f.bits), 32'h000003);
    check("ovw_second_gap", 32'(f.gap), 32'(GAP));
    wait_idle();
    check("ovw_count", 32'(overwrite_cnt_o), 32'd1);

    // Divider change mid-frame applies only to the following frame
    sclk_div_i = 8'd1;
    strobe(16'hBEEF);
    repeat (8) @(negedge clk_i);
    sclk_div_i = 8'd4;
    strobe(16'hCAFE);
    wait_frame(f);
    check("div_chg_first_low", 32'(f.low), 32'd50);
    check("div_chg_first_bits", 32'(f.bits), 32'h00BEEF);
    wait_frame(f);
    check("div_chg_second_low", 32'(f.low), 32'd200);
    check("div_chg_second_bits", 32'(f.bits), 32'h00CAFE);
    check("div_chg_second_gap", 32'(f.gap), 32'(GAP));
    wait_idle();

    // Reset during bit 10 aborts the frame without a done pulse
    sclk_div_i = 8'd1;
    d0 = done_cnt;
    strobe(16'h5A3C);
    repeat (21) @(negedge clk_i);
    check("abort_mid_frame_sclk_low", 32'(dac_sclk_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("abort_sync_n", 32'(dac_sync_n_o), 32'd1);
    check("abort_sclk", 32'(dac_sclk_o), 32'd1);
    check("abort_sdo", 32'(dac_sdo_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_ovw", 32'(overwrite_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_not_resent", 32'(busy_o), 32'd0);
    fq.delete();
    strobe(16'h1234);
    wait_frame(f);
    check("after_abort_bits", 32'(f.bits), 32'h001234);
    check("after_abort_low", 32'(f.low), 32'd50);
    check("after_abort_pulses", 32'(f.pulses), 32'd24);
    wait_idle();

    // Random strobes, divider changes and rare resets against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_i);
      motor_data_en_i = ($urandom_range(0, 9) == 0);
      motor_data_i    = 16'($urandom);
      if ($urandom_range(0, 199) == 0) sclk_div_i = 8'($urandom_range(0, 3));
      rst_i = ($urandom_range(0, 1499) == 0);
    end
    @(negedge clk_i);
    motor_data_en_i = 1'b0;
    rst_i = 1'b0;
    wait_idle();

    // Continuous strobes: saturating counter, back-to-back frames
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    sclk_div_i = 8'd1;
    @(negedge clk_i);
    fq.delete();
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk_i);
      motor_data_en_i = 1'b1;
      motor_data_i    = 16'(i);
    end
    @(negedge clk_i);
    motor_data_en_i = 1'b0;
    wait_idle();
    check("sat_ovw", 32'(overwrite_cnt_o), 32'hFFFF);
    check("sat_frame_count_min", 32'(fq.size() > 1200), 32'd1);
    for (int i = 0; i < fq.size(); i++) begin
      if (i > 0) check("sat_gap", 32'(fq[i].gap), 32'(GAP));
      check("sat_low", 32'(fq[i].low), 32'd50);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
